// File: rtl/damage_calc_seq.sv
// Sequential damage calculator: latches a request, multiplies, runs a restoring
// divider, scales, then applies crit/STAB/type modifiers with saturation.
module damage_calc_seq #(
  parameter int STAT_W = 8,
  parameter int DMG_W  = 16,
  parameter int LEVEL  = 50
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              physical,
  input  logic              crit,
  input  logic [4:0]        move_type,
  input  logic [4:0]        atk_type1,
  input  logic [4:0]        atk_type2,
  input  logic [4:0]        def_type1,
  input  logic [4:0]        def_type2,
  input  logic [STAT_W-1:0] power,
  input  logic [STAT_W-1:0] attack,
  input  logic [STAT_W-1:0] defense,
  input  logic [STAT_W-1:0] sp_att,
  input  logic [STAT_W-1:0] sp_def,
  output logic              busy,
  output logic              done,
  output logic [DMG_W-1:0]  damage,
  output logic [4:0]        eff_q
);

  localparam int LVLF  = 2 * LEVEL / 5 + 2;
  localparam int NUM_W = 2 * STAT_W + $clog2(LVLF + 1);
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam int MOD_W = NUM_W + 7;
  localparam logic [MOD_W-1:0] SAT = MOD_W'({DMG_W{1'b1}});

  typedef enum logic [2:0] {IDLE, MUL, DIV, SCALE, MOD, DONE} state_t;

  state_t             state;
  logic               crit_r, stab_r;
  logic [4:0]         eff_r;
  logic [STAT_W-1:0]  power_r, a_r, d_r;
  logic [NUM_W-1:0]   quo, base;
  logic [STAT_W-1:0]  rem;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [4:0] clamp_type(input logic [4:0] t);
    return (t > 5'd18) ? 5'd18 : t;
  endfunction

  // Chart entry in half units: 0 immune, 1 resisted, 2 neutral, 4 super-effective.
  function automatic logic [2:0] chart(input logic [4:0] m, input logic [4:0] d);
    logic [2:0] r;
    r = 3'd2;
    case (m)
      5'd0:  case (d) 5'd5, 5'd8: r = 3'd1; 5'd7: r = 3'd0; default: ; endcase
      5'd1:  case (d) 5'd0, 5'd5, 5'd8, 5'd14, 5'd16: r = 3'd4;
                      5'd2, 5'd3, 5'd6, 5'd13, 5'd17: r = 3'd1; 5'd7: r = 3'd0; default: ; endcase
      5'd2:  case (d) 5'd1, 5'd6, 5'd11: r = 3'd4; 5'd5, 5'd8, 5'd12: r = 3'd1; default: ; endcase
      5'd3:  case (d) 5'd11, 5'd17: r = 3'd4; 5'd3, 5'd4, 5'd5, 5'd7: r = 3'd1; 5'd8: r = 3'd0; default: ; endcase
      5'd4:  case (d) 5'd3, 5'd5, 5'd8, 5'd9, 5'd12: r = 3'd4; 5'd6, 5'd11: r = 3'd1; 5'd2: r = 3'd0; default: ; endcase
      5'd5:  case (d) 5'd2, 5'd6, 5'd9, 5'd14: r = 3'd4; 5'd1, 5'd4, 5'd8: r = 3'd1; default: ; endcase
      5'd6:  case (d) 5'd11, 5'd13, 5'd16: r = 3'd4;
                      5'd1, 5'd2, 5'd3, 5'd7, 5'd8, 5'd9, 5'd17: r = 3'd1; default: ; endcase
      5'd7:  case (d) 5'd7, 5'd13: r = 3'd4; 5'd16: r = 3'd1; 5'd0: r = 3'd0; default: ; endcase
      5'd8:  case (d) 5'd5, 5'd14, 5'd17: r = 3'd4; 5'd8, 5'd9, 5'd10, 5'd12: r = 3'd1; default: ; endcase
      5'd9:  case (d) 5'd6, 5'd8, 5'd11, 5'd14: r = 3'd4; 5'd5, 5'd9, 5'd10, 5'd15: r = 3'd1; default: ; endcase
      5'd10: case (d) 5'd4, 5'd5, 5'd9: r = 3'd4; 5'd10, 5'd11, 5'd15: r = 3'd1; default: ; endcase
      5'd11: case (d) 5'd4, 5'd5, 5'd10: r = 3'd4;
                      5'd2, 5'd3, 5'd6, 5'd8, 5'd9, 5'd11, 5'd15: r = 3'd1; default: ; endcase
      5'd12: case (d) 5'd2, 5'd10: r = 3'd4; 5'd11, 5'd12, 5'd15: r = 3'd1; 5'd4: r = 3'd0; default: ; endcase
      5'd13: case (d) 5'd1, 5'd3: r = 3'd4; 5'd8, 5'd13: r = 3'd1; 5'd16: r = 3'd0; default: ; endcase
      5'd14: case (d) 5'd2, 5'd4, 5'd11, 5'd15: r = 3'd4; 5'd8, 5'd9, 5'd10, 5'd14: r = 3'd1; default: ; endcase
      5'd15: case (d) 5'd15: r = 3'd4; 5'd8: r = 3'd1; 5'd17: r = 3'd0; default: ; endcase
      5'd16: case (d) 5'd7, 5'd13: r = 3'd4; 5'd1, 5'd16, 5'd17: r = 3'd1; default: ; endcase
      5'd17: case (d) 5'd1, 5'd15, 5'd16: r = 3'd4; 5'd3, 5'd8, 5'd9: r = 3'd1; default: ; endcase
      default: ;
    endcase
    return r;
  endfunction

  logic [4:0]        mv_c, a1_c, a2_c, d1_c, d2_c;
  logic [2:0]        e1, e2;
  logic [4:0]        eff_in;
  logic              stab_in;
  logic [STAT_W-1:0] d_in;

  always_comb begin
    mv_c    = clamp_type(move_type);
    a1_c    = clamp_type(atk_type1);
    a2_c    = clamp_type(atk_type2);
    d1_c    = clamp_type(def_type1);
    d2_c    = clamp_type(def_type2);
    e1      = chart(mv_c, d1_c);
    e2      = (d2_c == d1_c) ? 3'd2 : chart(mv_c, d2_c);
    eff_in  = 5'(e1 * e2);
    stab_in = (mv_c != 5'd18) && ((mv_c == a1_c) || (mv_c == a2_c));
    d_in    = physical ? defense : sp_def;
    if (d_in == '0) d_in = STAT_W'(1);
  end

  logic [STAT_W:0]   trial;
  logic              fits;
  logic [MOD_W-1:0]  v1, v2, v3;
  logic [DMG_W-1:0]  dmg_out;

  always_comb begin
    trial = {rem, quo[NUM_W-1]};
    fits  = (trial >= {1'b0, d_r});
    v1    = crit_r ? (MOD_W'(base) << 1) : MOD_W'(base);
    v2    = stab_r ? ((v1 * MOD_W'(3)) >> 1) : v1;
    v3    = (v2 * MOD_W'(eff_r)) >> 2;
    dmg_out = (v3 > SAT) ? {DMG_W{1'b1}} : v3[DMG_W-1:0];
    if (eff_r == 5'd0)        dmg_out = '0;
    else if (dmg_out == '0)   dmg_out = DMG_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      damage  <= '0;
      eff_q   <= '0;
      crit_r  <= 1'b0;
      stab_r  <= 1'b0;
      eff_r   <= '0;
      power_r <= '0;
      a_r     <= '0;
      d_r     <= '0;
      quo     <= '0;
      base    <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            crit_r  <= crit;
            stab_r  <= stab_in;
            eff_r   <= eff_in;
            power_r <= power;
            a_r     <= physical ? attack : sp_att;
            d_r     <= d_in;
            busy    <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          quo   <= NUM_W'(LVLF) * NUM_W'(power_r) * NUM_W'(a_r);
          rem   <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          // One restoring step: shift in the next numerator bit, subtract if it fits.
          if (fits) rem <= STAT_W'(trial - {1'b0, d_r});
          else      rem <= trial[STAT_W-1:0];
          quo <= {quo[NUM_W-2:0], fits};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NUM_W - 1)) state <= SCALE;
        end
        SCALE: begin
          base  <= quo / NUM_W'(50) + NUM_W'(2);
          state <= MOD;
        end
        MOD: begin
          damage <= dmg_out;
          eff_q  <= eff_r;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_damage_calc_seq.sv
// Directed bench for damage_calc_seq: hand-computed damage/eff_q/latency vectors
// plus reset-abort and start-while-busy control cases.
module tb_damage_calc_seq;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0, physical = 1'b0, crit = 1'b0;
  logic [4:0]  move_type = '0, atk_type1 = '0, atk_type2 = '0, def_type1 = '0, def_type2 = '0;
  logic [7:0]  power = '0, attack = '0, defense = '0, sp_att = '0, sp_def = '0;
  logic        busy, done;
  logic [15:0] damage;
  logic [4:0]  eff_q;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int lat;

  damage_calc_seq dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .physical(physical), .crit(crit),
    .move_type(move_type), .atk_type1(atk_type1), .atk_type2(atk_type2),
    .def_type1(def_type1), .def_type2(def_type2),
    .power(power), .attack(attack), .defense(defense), .sp_att(sp_att), .sp_def(sp_def),
    .busy(busy), .done(done), .damage(damage), .eff_q(eff_q)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (done) done_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic ph, input logic cr, input logic [4:0] mv, a1, a2, d1, d2,
                         input logic [7:0] pw, at, df, sa, sd);
    physical = ph; crit = cr; move_type = mv; atk_type1 = a1; atk_type2 = a2;
    def_type1 = d1; def_type2 = d2; power = pw; attack = at; defense = df;
    sp_att = sa; sp_def = sd;
  endtask

  // Drive a request and return just after the accept edge.
  task automatic launch(input logic ph, input logic cr, input logic [4:0] mv, a1, a2, d1, d2,
                        input logic [7:0] pw, at, df, sa, sd);
    @(negedge Clk);
    set_ops(ph, cr, mv, a1, a2, d1, d2, pw, at, df, sa, sd);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input string tag, input logic ph, input logic cr,
                     input logic [4:0] mv, a1, a2, d1, d2,
                     input logic [7:0] pw, at, df, sa, sd,
                     input int exp_dmg, input int exp_eff);
    launch(ph, cr, mv, a1, a2, d1, d2, pw, at, df, sa, sd);
    check({tag, "_busy"}, int'(busy), 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge Clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 24);
    check({tag, "_busy_in_done"}, int'(busy), 0);
    check({tag, "_damage"}, int'(damage), exp_dmg);
    check({tag, "_eff_q"}, int'(eff_q), exp_eff);
    $display("txn %s: damage=%0d eff_q=%0d latency=%0d", tag, damage, eff_q, lat);
    @(posedge Clk);
    #1 check({tag, "_done_pulse_end"}, int'(done), 0);
  endtask

  initial begin
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_damage", int'(damage), 0);
    check("rst_eff_q", int'(eff_q), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    //   tag         ph cr  mv  a1  a2  d1  d2   pw   at   df   sa   sd   dmg    eff
    run("stab",      1, 0,  0,  0, 18,  0, 18,  40, 100, 100,   0,   0,    28,  4);
    run("immune",    1, 0,  7,  0, 18,  0, 18,  40, 100, 100,   0,   0,     0,  0);
    run("super_sp",  0, 0, 10,  9, 18,  9,  5,  90,   0,   0, 120,  80,   244, 16);
    run("saturate",  1, 1,  9,  9, 18, 11,  6, 255, 255,   1,   0,   0, 65535, 16);
    run("min_dmg",   1, 0, 11, 18, 18,  9,  2,   1,   1, 255,   0,   0,     1,  1);
    run("def_zero",  1, 0,  0, 18, 18,  0, 18,  50,  60,   0,   0,   0,  1322,  4);
    run("def_one",   1, 0,  0, 18, 18,  0, 18,  50,  60,   1,   0,   0,  1322,  4);
    run("same_def",  1, 0, 10, 18, 18,  9,  9,  40, 100, 100,   0,   0,    38,  8);
    run("clamp",     1, 0, 25, 25, 18,  7, 18,  40, 100, 100,   0,   0,    19,  4);

    // Reset 10 cycles into a calculation: outputs clear, no done pulse afterwards.
    done_cnt = 0;
    launch(1, 0, 0, 0, 18, 0, 18, 40, 100, 100, 0, 0);
    repeat (10) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #2;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_damage", int'(damage), 0);
    check("abort_eff_q", int'(eff_q), 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (40) @(posedge Clk);
    #1 check("abort_no_done", done_cnt, 0);
    $display("txn abort: done pulses after reset=%0d", done_cnt);
    run("post_reset", 1, 0, 0, 0, 18, 0, 18, 40, 100, 100, 0, 0, 28, 4);

    // Second start while busy, with different operands, must be ignored.
    done_cnt = 0;
    launch(1, 0, 0, 0, 18, 0, 18, 40, 100, 100, 0, 0);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    set_ops(1, 1, 9, 9, 18, 11, 6, 255, 255, 1, 0, 0);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (60) @(posedge Clk);
    #1;
    check("busy_ignore_pulses", done_cnt, 1);
    check("busy_ignore_damage", int'(damage), 28);
    check("busy_ignore_eff_q", int'(eff_q), 4);
    $display("txn busy_ignore: done pulses=%0d damage=%0d", done_cnt, damage);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/damage_calc_seq.md
DAMAGE_CALC_SEQ -- requirements
Module: damage_calc_seq

Interface
REQ-001 Parameter STAT_W, default 8: width of power, attack, defense, sp_att and sp_def.
REQ-002 Parameter DMG_W, default 16: width of damage.
REQ-003 Parameter LEVEL, default 50: attacker level; localparam LVLF = 2*LEVEL/5+2 (22 at default).
REQ-004 Localparam NUM_W = 2*STAT_W + $clog2(LVLF+1): numerator width (21 at defaults).
REQ-005 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request; accepted only in IDLE.
REQ-008 physical  in  1  1 selects attack/defense; 0 selects sp_att/sp_def.
REQ-009 crit  in  1  critical hit, applies x2.
REQ-010 move_type, atk_type1, atk_type2, def_type1, def_type2  in  5 each  type codes 0-18.
REQ-011 power, attack, defense, sp_att, sp_def  in  STAT_W each  unsigned operands.
REQ-012 busy  out  1  high from the accept edge until done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 damage  out  DMG_W  result; held until the next accept.
REQ-015 eff_q  out  5  combined type effectiveness in quarter units (0,1,2,4,8,16).

Function
REQ-016 Type codes SHALL use this order: Normal, Fighting, Flying, Poison, Ground, Rock, Bug, Ghost, Steel, Fire, Water, Grass, Electric, Psychic, Ice, Dragon, Dark, Fairy, None(18); codes 19-31 SHALL be treated as 18.
REQ-017 The chart SHALL be the standard 18-type chart; row 18 and column 18 SHALL be all x1. Each entry SHALL be stored in half units: 0, 1, 2 or 4.
REQ-018 eff_q SHALL equal chart[move][def1]*chart[move][def2]; if def_type2 equals def_type1, eff_q SHALL equal chart[move][def1]*2.
REQ-019 STAB SHALL apply when move_type is not 18 and move_type equals atk_type1 or atk_type2.
REQ-020 The FSM SHALL have states IDLE, MUL, DIV, SCALE, MOD and DONE.
REQ-021 When start=1 in IDLE, all inputs SHALL be latched at that edge and busy SHALL rise.
REQ-022 MUL SHALL last 1 cycle and compute N = LVLF*power*A, where A is the selected attack stat.
REQ-023 DIV SHALL be a restoring divider computing N/D, one quotient bit per cycle, for NUM_W cycles; D is the selected defense stat, and D=0 SHALL be treated as 1.
REQ-024 SCALE SHALL last 1 cycle and compute B = floor(quotient/50)+2.
REQ-025 MOD SHALL last 1 cycle and apply, in order, each step floored:
- x2 if crit;
- x3/2 if STAB;
- x eff_q/4.
REQ-026 The MOD result SHALL saturate to 2^DMG_W-1.
REQ-027 If eff_q is nonzero and the result is 0, damage SHALL be 1; if eff_q is 0, damage SHALL be 0.
REQ-028 damage and eff_q SHALL update on the MOD-to-DONE edge.
REQ-029 In DONE, done SHALL be 1 and busy 0 for one cycle, then the FSM SHALL return to IDLE.
REQ-030 Latency SHALL be fixed: done high in the cycle after edge NUM_W+3, counting the accept edge as 0 (24 cycles at defaults), independent of operand values.
REQ-031 start while busy or in DONE SHALL be ignored; latched operands SHALL be unaffected by input changes after the accept edge.
REQ-032 Internal widths SHALL be sufficient that no intermediate product overflows before saturation.

Reset
REQ-033 While Reset_n=0, the FSM SHALL be in IDLE with busy=0, done=0, damage=0 and eff_q=0, regardless of Clk.
REQ-034 Reset asserted mid-operation SHALL abort the calculation without a done pulse; the first start after release SHALL behave normally.

Verification
REQ-035 The bench SHALL cover this STAB case: physical, power=40, attack=100, defense=100, move 0, atk 0/18, def 0/18, crit=0 -> damage=28, eff_q=4, done 24 cycles after accept.
REQ-036 The bench SHALL cover these effectiveness cases:
- Immune: move 7 vs def 0/18 -> damage=0, eff_q=0.
- Super-effective, special: power=90, sp_att=120, sp_def=80, move 10, atk 9/18, def 9/5 -> damage=244, eff_q=16.
REQ-037 The bench SHALL cover this saturation case: power=255, attack=255, defense=1, crit=1, STAB, eff_q=16 -> damage=65535.
REQ-038 The bench SHALL cover these edge cases:
- Minimum damage: power=1, attack=1, defense=255, move 11, def 9/2 -> damage=1, eff_q=1.
- defense=0 SHALL give the same result as defense=1.
REQ-039 The bench SHALL cover these control cases:
- Reset_n low at cycle 10 -> outputs cleared, no done pulse.
- start pulsed while busy -> ignored; exactly one done pulse for the first request.
